// File: rtl/seg7_scan_scheduler.sv
// Time-multiplexed scan driver for an 8-digit common-cathode 7-segment display.
// Frames arrive via valid/ready into a pending buffer and are shown only from the next frame boundary.
module seg7_scan_scheduler #(
  parameter int NUM_DIGITS = 8,
  parameter int DIV        = 4096,
  parameter int BLANK      = 256
) (
  input  logic        clk,
  input  logic        nRST,
  input  logic        en,
  input  logic        frame_valid,
  output logic        frame_ready,
  input  logic [63:0] frame_data,
  output logic        frame_done,
  output logic [7:0]  SEG_COM,
  output logic [7:0]  SEG_DATA
);

  localparam int CW = $clog2(DIV);
  localparam int SW = 3;
  localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] BLANK_C   = CW'(BLANK);
  localparam logic [SW-1:0] SLOT_LAST = SW'(NUM_DIGITS - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] slot_q, slot_d;
  logic [63:0]   shadow_q, shadow_d;
  logic [63:0]   pending_q, pending_d;
  logic          pendingFull_q, pendingFull_d;
  logic [7:0]    segCom_q, segCom_d;
  logic [7:0]    segData_q, segData_d;
  logic          frameDone_q, frameDone_d;

  logic          boundary;
  logic          transfer;
  logic          lit;
  logic [7:0]    digit;

  assign frame_ready = ~pendingFull_q;
  assign frame_done  = frameDone_q;
  assign SEG_COM     = segCom_q;
  assign SEG_DATA    = segData_q;

  always_comb begin
    boundary = en && (slot_q == SLOT_LAST) && (cnt_q == CNT_LAST);
    transfer = frame_valid && !pendingFull_q;
    digit    = shadow_q[{slot_q, 3'b000} +: 8];
    lit      = en && (cnt_q >= BLANK_C);

    cnt_d         = cnt_q;
    slot_d        = slot_q;
    shadow_d      = shadow_q;
    pending_d     = pending_q;
    pendingFull_d = pendingFull_q;

    if (!en) begin
      cnt_d  = '0;
      slot_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d  = '0;
      slot_d = (slot_q == SLOT_LAST) ? '0 : slot_q + 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end

    // Commit needs a full buffer and transfer needs an empty one, so a frame
    // accepted on the boundary cycle waits for the following boundary.
    if (boundary && pendingFull_q) begin
      shadow_d      = pending_q;
      pendingFull_d = 1'b0;
    end else if (transfer) begin
      pending_d     = frame_data;
      pendingFull_d = 1'b1;
    end

    segCom_d    = lit ? ~(8'b1 << slot_q) : 8'hFF;
    segData_d   = lit ? digit : 8'h00;
    frameDone_d = boundary;
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      cnt_q         <= '0;
      slot_q        <= '0;
      shadow_q      <= '0;
      pending_q     <= '0;
      pendingFull_q <= 1'b0;
      segCom_q      <= 8'hFF;
      segData_q     <= 8'h00;
      frameDone_q   <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      slot_q        <= slot_d;
      shadow_q      <= shadow_d;
      pending_q     <= pending_d;
      pendingFull_q <= pendingFull_d;
      segCom_q      <= segCom_d;
      segData_q     <= segData_d;
      frameDone_q   <= frameDone_d;
    end
  end

endmodule

// File: tb/tb_seg7_scan_scheduler.sv
// Scoreboard bench for seg7_scan_scheduler with NUM_DIGITS=8, DIV=4, BLANK=1.
// Stimulus pushes the expected registered outputs; a monitor pops and compares after each edge.
module tb_seg7_scan_scheduler;

  localparam logic [63:0] FRAME_A = 64'h0000_0000_60FC_FC00;
  localparam logic [63:0] FRAME_B = 64'h0102_0408_1020_4080;
  localparam logic [63:0] FRAME_C = 64'hFFEE_DDCC_BBAA_9988;
  localparam logic [63:0] FRAME_D = 64'h1122_3344_5566_7788;
  localparam logic [63:0] FRAME_E = 64'hA5A5_5A5A_C3C3_3C3C;
  localparam logic [63:0] FRAME_F = 64'h0F0F_F0F0_7E7E_E7E7;

  logic        clk = 1'b0;
  logic        nRST;
  logic        en;
  logic        frame_valid;
  logic        frame_ready;
  logic [63:0] frame_data;
  logic        frame_done;
  logic [7:0]  SEG_COM;
  logic [7:0]  SEG_DATA;

  seg7_scan_scheduler #(
    .NUM_DIGITS(8),
    .DIV(4),
    .BLANK(1)
  ) dut (
    .clk(clk),
    .nRST(nRST),
    .en(en),
    .frame_valid(frame_valid),
    .frame_ready(frame_ready),
    .frame_data(frame_data),
    .frame_done(frame_done),
    .SEG_COM(SEG_COM),
    .SEG_DATA(SEG_DATA)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] com;
    logic [7:0] data;
    logic       done;
  } exp_t;

  exp_t expQ[$];
  int   nChecks = 0;
  int   nFails  = 0;

  // Expected visible state: phase 0..31 within the frame, shown and pending frames.
  int          mPhase;
  logic [63:0] mShadow;
  logic [63:0] mPending;
  logic        mFull;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    nChecks++;
    if (act !== req) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("SEG_COM", {56'b0, SEG_COM}, {56'b0, e.com});
        checkOutput("SEG_DATA", {56'b0, SEG_DATA}, {56'b0, e.data});
        checkOutput("frame_done", {63'b0, frame_done}, {63'b0, e.done});
      end
    end
  end

  task automatic applyStimulus(input logic enIn, input logic validIn, input logic [63:0] dataIn,
                               output logic accepted);
    exp_t e;
    int   slot;
    int   cnt;
    logic boundary;
    @(negedge clk);
    en          = enIn;
    frame_valid = validIn;
    frame_data  = dataIn;
    checkOutput("frame_ready", {63'b0, frame_ready}, {63'b0, !mFull});
    if (enIn) begin
      slot   = mPhase / 4;
      cnt    = mPhase % 4;
      e.com  = (cnt >= 1) ? ~(8'b1 << slot) : 8'hFF;
      e.data = (cnt >= 1) ? mShadow[slot*8 +: 8] : 8'h00;
      e.done = (mPhase == 31);
    end else begin
      e.com  = 8'hFF;
      e.data = 8'h00;
      e.done = 1'b0;
    end
    expQ.push_back(e);
    boundary = enIn && (mPhase == 31);
    accepted = validIn && !mFull;
    if (boundary && mFull) begin
      mShadow = mPending;
      mFull   = 1'b0;
    end else if (accepted) begin
      mPending = dataIn;
      mFull    = 1'b1;
    end
    mPhase = enIn ? (mPhase + 1) % 32 : 0;
  endtask

  task automatic runCycles(input int n, input logic enIn);
    logic acc;
    for (int i = 0; i < n; i++) applyStimulus(enIn, 1'b0, 64'h0, acc);
  endtask

  task automatic runToPhase(input int target);
    logic acc;
    for (int i = 0; i < 64 && mPhase != target; i++) applyStimulus(1'b1, 1'b0, 64'h0, acc);
  endtask

  initial begin
    logic acc;
    logic reached;

    nRST = 1'b0; en = 1'b0; frame_valid = 1'b0; frame_data = '0;
    mPhase = 0; mShadow = '0; mPending = '0; mFull = 1'b0;
    #12;
    checkOutput("reset SEG_COM", {56'b0, SEG_COM}, 64'hFF);
    checkOutput("reset SEG_DATA", {56'b0, SEG_DATA}, 64'h00);
    checkOutput("reset frame_done", {63'b0, frame_done}, 64'h0);
    checkOutput("reset frame_ready", {63'b0, frame_ready}, 64'h1);
    @(negedge clk);
    nRST = 1'b1;

    $display("[TB] idle scan with empty frame");
    runCycles(70, 1'b1);

    $display("[TB] frame A, visible after the next boundary");
    applyStimulus(1'b1, 1'b1, FRAME_A, acc);
    reached = 1'b0;
    for (int i = 0; i < 200 && !reached; i++) begin
      applyStimulus(1'b1, 1'b0, 64'h0, acc);
      reached = (mShadow == FRAME_A) && (mPhase == 6);
    end
    checkOutput("frame A reached slot1", {63'b0, reached}, 64'h1);
    @(posedge clk);
    #2;
    checkOutput("slot1 COM", {56'b0, SEG_COM}, 64'hFD);
    checkOutput("slot1 DATA", {56'b0, SEG_DATA}, 64'hFC);
    runCycles(10, 1'b1);

    $display("[TB] back-to-back frames with held valid");
    applyStimulus(1'b1, 1'b1, FRAME_B, acc);
    acc = 1'b0;
    for (int i = 0; i < 100 && !acc; i++) applyStimulus(1'b1, 1'b1, FRAME_C, acc);
    runCycles(70, 1'b1);

    $display("[TB] transfer on the boundary cycle");
    runToPhase(31);
    applyStimulus(1'b1, 1'b1, FRAME_D, acc);
    runCycles(70, 1'b1);

    $display("[TB] enable dropped at slot 5 with a frame pending");
    applyStimulus(1'b1, 1'b1, FRAME_E, acc);
    runToPhase(20);
    runCycles(10, 1'b0);
    runCycles(80, 1'b1);

    $display("[TB] asynchronous reset mid-slot with a frame pending");
    runToPhase(10);
    applyStimulus(1'b1, 1'b1, FRAME_F, acc);
    applyStimulus(1'b1, 1'b0, 64'h0, acc);
    applyStimulus(1'b1, 1'b0, 64'h0, acc);
    @(posedge clk);
    #3;
    nRST = 1'b0; en = 1'b0; frame_valid = 1'b0;
    #1;
    checkOutput("async reset SEG_COM", {56'b0, SEG_COM}, 64'hFF);
    checkOutput("async reset SEG_DATA", {56'b0, SEG_DATA}, 64'h00);
    checkOutput("async reset frame_ready", {63'b0, frame_ready}, 64'h1);
    checkOutput("async reset frame_done", {63'b0, frame_done}, 64'h0);
    mPhase = 0; mShadow = '0; mPending = '0; mFull = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    nRST = 1'b1;
    runCycles(40, 1'b1);

    @(posedge clk);
    #2;
    checkOutput("scoreboard drained", 64'(expQ.size()), 64'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
